// File: rtl/galois_lfsr4.sv
// -----------------------------------------------------------------------------
// galois_lfsr4
//   Free-running 4-bit maximal-length Galois LFSR, polynomial x^4 + x + 1.
//   Steps through all 15 non-zero states with period 15. Starting from SEED
//   0001 the sequence is:
//   0001 0010 0100 1000 0011 0110 1100 1011 0101 1010 0111 1110 1111 1101 1001.
//
// Parameters
//   WIDTH : register width. Only 4 is supported.
//   TAPS  : XOR mask applied when the shifted-out MSB is 1 (4'b0011).
//   SEED  : value loaded on reset. Must be non-zero unless lockup recovery is
//           built in.
//
// Ports
//   clk   : rising-edge clock, sole clock domain
//   reset : synchronous, active-low reset. Loads SEED and wins over the update.
//   q     : current LFSR state, driven straight from the state register
//
// Build option
//   LFSR_LOCKUP_RECOVER_EN : when defined, the all-zero lockup state steps to
//   0001 instead of holding, and SEED == 0 becomes legal. Non-zero sequences
//   are identical in both builds.
// -----------------------------------------------------------------------------
module galois_lfsr4 #(
    parameter int             WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    // Elaboration-time configuration checks.
    if (WIDTH != 4) begin : g_bad_width
        $error("galois_lfsr4: WIDTH must be 4");
    end

`ifndef LFSR_LOCKUP_RECOVER_EN
    // Without recovery a zero seed would sit in the lockup state forever.
    if (SEED == '0) begin : g_bad_seed
        $error("galois_lfsr4: SEED must be non-zero without LFSR_LOCKUP_RECOVER_EN");
    end
`endif

    logic             msb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] q_next;

    assign msb = q[WIDTH-1];

    // Shift left by one; the bit falling off the top folds back in through
    // the tap mask (Galois form: XORs sit between stages, not in a chain).
    assign shifted[0] = 1'b0;
    for (genvar i = 1; i < WIDTH; i++) begin : g_shift
        assign shifted[i] = q[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_tap
        assign step[i] = shifted[i] ^ (msb & TAPS[i]);
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    // The all-zero state is a fixed point of the shift/XOR; kick it back onto
    // the main cycle at 0001.
    always_comb begin
        q_next = step;
        if (q == '0) begin
            q_next = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end
`else
    assign q_next = step;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_galois_lfsr4.sv
// -----------------------------------------------------------------------------
// tb_galois_lfsr4
//   Self-checking bench for galois_lfsr4. A GF(16) model (multiply by x,
//   reduce modulo x^4 + x + 1 = 19) tracks every instance and is compared on
//   each falling edge; directed checks against literal sequences pin the model.
// -----------------------------------------------------------------------------
module tb_galois_lfsr4;

    logic       clk;
    logic       reset;
    logic [3:0] q;
    logic [3:0] q_s8;
`ifdef LFSR_LOCKUP_RECOVER_EN
    logic [3:0] q_s0;
`endif

    int total = 0;
    int bad   = 0;

    galois_lfsr4 dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    galois_lfsr4 #(.SEED(4'b1000)) dut_s8 (
        .clk   (clk),
        .reset (reset),
        .q     (q_s8)
    );

`ifdef LFSR_LOCKUP_RECOVER_EN
    galois_lfsr4 #(.SEED(4'b0000)) dut_s0 (
        .clk   (clk),
        .reset (reset),
        .q     (q_s0)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiply by x in GF(2^4) with modulus x^4 + x + 1 (decimal 19).
    // Zero is a fixed point unless recovery is built in.
    function automatic int gf_step(input int v, input bit recover);
        int r;
        if (v == 0) return recover ? 1 : 0;
        r = v * 2;
        if (r >= 16) r = r ^ 19;
        return r;
    endfunction

    int mq, m8, m0;
    bit mvalid = 1'b0;
    bit recover_en;

`ifdef LFSR_LOCKUP_RECOVER_EN
    initial recover_en = 1'b1;
`else
    initial recover_en = 1'b0;
`endif

    always @(posedge clk) begin
        if (!reset) begin
            mq = 1;
            m8 = 8;
            m0 = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            mq = gf_step(mq, recover_en);
            m8 = gf_step(m8, recover_en);
            m0 = gf_step(m0, recover_en);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_q", q, 4'(mq));
            chk("model_s8", q_s8, 4'(m8));
`ifdef LFSR_LOCKUP_RECOVER_EN
            chk("model_s0", q_s0, 4'(m0));
`endif
        end
    end

    logic [3:0] seq [15];
    bit   [15:0] seen;

    initial begin
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1011,
                4'b0101, 4'b1010, 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001,
                4'b0001};

        // Reset held for 5 edges.
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_q", q, 4'b0001);
            chk("reset_s8", q_s8, 4'b1000);
`ifdef LFSR_LOCKUP_RECOVER_EN
            chk("reset_s0", q_s0, 4'b0000);
`endif
        end

        // Release and walk one full period.
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("seq", q, seq[i]);
            if (i == 0) chk("s8_first", q_s8, 4'b0011);
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (i == 0) chk("s0_recover", q_s0, 4'b0001);
            if (i == 1) chk("s0_next", q_s0, 4'b0010);
`endif
        end

        // Three full periods from reset.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = '0;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            total++;
            if (q === 4'b0000 || $isunknown(q)) begin
                bad++;
                $display("FAIL nonzero: got %b expected non-zero at edge %0d", q, e);
            end else begin
                seen[q] = 1'b1;
            end
            if (e % 15 == 0) begin
                chk("period_wrap", q, 4'b0001);
                total++;
                if (seen != 16'hFFFE) begin
                    bad++;
                    $display("FAIL period_cover: got %h expected fffe", seen);
                end
                seen = '0;
            end
        end

        // Mid-sequence reset while q == 1011.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(negedge clk);
        chk("pre_midreset", q, 4'b1011);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset", q, 4'b0001);
        reset = 1'b1;
        @(negedge clk);
        chk("post_midreset", q, 4'b0010);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
